// File: rtl/alu_seg7_scan.sv
// Registered N-bit ALU whose result is shown in hex on a time-multiplexed bank of 7-segment digits.
// One decoder runs per digit, and the scan FSM picks the digit to drive the shared segment lines.

module alu_seg7_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'h7E;  4'h1: seg = 7'h30;  4'h2: seg = 7'h6D;  4'h3: seg = 7'h79;
        4'h4: seg = 7'h33;  4'h5: seg = 7'h5B;  4'h6: seg = 7'h5F;  4'h7: seg = 7'h70;
        4'h8: seg = 7'h7F;  4'h9: seg = 7'h7B;  4'hA: seg = 7'h77;  4'hB: seg = 7'h1F;
        4'hC: seg = 7'h4E;  4'hD: seg = 7'h3D;  4'hE: seg = 7'h4F;  default: seg = 7'h47;
      endcase
    end
  end
endmodule

module alu_seg7_scan #(
  parameter int N        = 8,
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N-1:0]           a,
  input  logic [N-1:0]           b,
  input  logic [1:0]             op_code,
  input  logic                   enable,
  output logic [N-1:0]           result,
  output logic                   flag,
  output logic [(N+3)/4-1:0]     dig_en,
  output logic [6:0]             seg
);
  localparam int DIGITS = (N + 3) / 4;
  localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [N:0]              sum, diff;
  logic [4*DIGITS-1:0]     res_ext;
  logic [DIGITS-1:0][3:0]  nib;
  logic [DIGITS-1:0]       lz;
  logic [DIGITS-1:0]       blank;
  logic [DIGITS-1:0][6:0]  seg_all;

  // Bit N of the widened sum/difference is the carry/borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      flag   <= 1'b0;
    end else if (in_valid) begin
      case (op_code)
        2'b00:   {flag, result} <= sum;
        2'b01:   begin result <= a | b; flag <= 1'b0; end
        2'b10:   {flag, result} <= diff;
        default: begin result <= a ^ b; flag <= 1'b0; end
      endcase
    end
  end

  always_comb begin
    res_ext        = '0;
    res_ext[N-1:0] = result;
  end

  // lz[k]: every nibble from k to the top digit is zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    localparam bit CAN_BLANK = (BLANK_LZ != 0) && (k > 0);
    assign nib[k]   = res_ext[4*k +: 4];
    assign lz[k]    = ~|res_ext[4*DIGITS-1:4*k];
    assign blank[k] = CAN_BLANK & lz[k];
    alu_seg7_dec u_dec (.nib(nib[k]), .blank(blank[k]), .seg(seg_all[k]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      seg    <= 7'h00;
      dig_en <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          idx    <= '0;
          seg    <= 7'h00;
          dig_en <= '0;
          if (enable) state <= SCAN;
        end
        SCAN: begin
          if (!enable) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            seg    <= 7'h00;
            dig_en <= '0;
          end else begin
            seg    <= seg_all[idx];
            dig_en <= DIGITS'(1) << idx;
            if (cnt == CW'(SCAN_DIV - 1)) begin
              cnt <= '0;
              idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seg7_scan.sv
// Scoreboard bench: one DUT without and one with leading-zero blanking share the same stimulus.
// Expected outputs are pushed before each edge and popped right after it.
module tb_alu_seg7_scan;
  localparam int SD = 4;
  localparam int DG = 2;

  typedef struct packed {
    logic [7:0] res;
    logic       flag;
    logic [1:0] den;
    logic [6:0] seg;
    logic [6:0] segb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, enable;
  logic [7:0] a, b;
  logic [1:0] op_code;
  logic [7:0] res0, res1;
  logic       flag0, flag1;
  logic [1:0] den0, den1;
  logic [6:0] seg0, seg1;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] m_res = 8'h00;
  logic       m_flag = 1'b0;
  logic       m_on = 1'b0;
  int         m_t = 0;
  exp_t       q[$];

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always #5 clk = ~clk;

  alu_seg7_scan #(.N(8), .SCAN_DIV(SD), .BLANK_LZ(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op_code(op_code),
    .enable(enable), .result(res0), .flag(flag0), .dig_en(den0), .seg(seg0));

  alu_seg7_scan #(.N(8), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op_code(op_code),
    .enable(enable), .result(res1), .flag(flag1), .dig_en(den1), .seg(seg1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model one edge from the current inputs, then clock and compare both DUTs.
  task automatic cyc();
    exp_t       e;
    logic [8:0] w;
    logic [3:0] nb;
    int         d;
    e = '0;
    if (!rst_n) begin
      m_res = 8'h00; m_flag = 1'b0; m_on = 1'b0; m_t = 0;
    end else begin
      if (m_on && enable) begin
        d      = (m_t / SD) % DG;
        nb     = m_res[4*d +: 4];
        e.seg  = seg_tab[nb];
        e.segb = (d > 0 && (m_res >> (4*d)) == 8'h00) ? 7'h00 : e.seg;
        e.den  = 2'(1 << d);
        m_t++;
      end else begin
        m_t = 0;
      end
      if (in_valid) begin
        case (op_code)
          2'b00:   w = {1'b0, a} + {1'b0, b};
          2'b01:   w = {1'b0, a | b};
          2'b10:   w = {1'b0, a} - {1'b0, b};
          default: w = {1'b0, a ^ b};
        endcase
        m_res  = w[7:0];
        m_flag = w[8];
      end
      m_on = enable;
    end
    e.res  = m_res;
    e.flag = m_flag;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_res",   res0,  e.res);
    chk("sb_flag",  flag0, e.flag);
    chk("sb_den",   den0,  e.den);
    chk("sb_seg",   seg0,  e.seg);
    chk("sb_res_b", res1,  e.res);
    chk("sb_den_b", den1,  e.den);
    chk("sb_seg_b", seg1,  e.segb);
  endtask

  // Load an operation with the display off, re-enable, and check one full scan of both digits.
  task automatic show(input logic [1:0] op, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] er, input logic ef,
                      input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] b1);
    enable = 1'b0; cyc();
    in_valid = 1'b1; op_code = op; a = aa; b = bb; cyc();
    in_valid = 1'b0;
    chk("alu_res", res0, er);
    chk("alu_flag", flag0, ef);
    enable = 1'b1; cyc();
    chk("scan_gap_den", den0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("show_den", den0, (i < 4) ? 2'b01 : 2'b10);
      chk("show_seg", seg0, (i < 4) ? s0 : s1);
      chk("show_seg_b", seg1, (i < 4) ? s0 : b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; enable = 1'b1;
    a = 8'h9C; b = 8'h7A; op_code = 2'b00;
    cyc(); cyc();
    chk("rst_res", res0, 8'h00);
    chk("rst_flag", flag0, 1'b0);
    chk("rst_seg", seg0, 7'h00);
    chk("rst_den", den0, 2'b00);

    rst_n = 1'b1; in_valid = 1'b0;
    cyc();
    chk("post_rst_gap", den0, 2'b00);
    cyc();
    chk("post_rst_den", den0, 2'b01);
    chk("post_rst_seg", seg0, 7'h7E);

    show(2'b00, 8'h9C, 8'h7A, 8'h16, 1'b1, 7'h5F, 7'h30, 7'h30);
    show(2'b10, 8'h05, 8'h07, 8'hFE, 1'b1, 7'h4F, 7'h47, 7'h47);
    show(2'b11, 8'h3C, 8'hA5, 8'h99, 1'b0, 7'h7B, 7'h7B, 7'h7B);

    // enable drops in the second cycle of digit 1
    for (int i = 0; i < 5; i++) cyc();
    chk("mid_dig1", den0, 2'b10);
    enable = 1'b0; cyc();
    chk("drop_den", den0, 2'b00);
    chk("drop_seg", seg0, 7'h00);
    enable = 1'b1; cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("reen_den0", den0, 2'b01);
    end
    cyc();
    chk("reen_den1", den0, 2'b10);

    // result update while digit 0 shows 6
    show(2'b00, 8'h9C, 8'h7A, 8'h16, 1'b1, 7'h5F, 7'h30, 7'h30);
    cyc();
    chk("upd_pre_seg", seg0, 7'h5F);
    in_valid = 1'b1; op_code = 2'b01; a = 8'h01; b = 8'h02; cyc();
    in_valid = 1'b0;
    chk("upd_res", res0, 8'h03);
    chk("upd_strobe_seg", seg0, 7'h5F);
    cyc();
    chk("upd_seg", seg0, 7'h79);
    chk("upd_den", den0, 2'b01);
    cyc();
    chk("upd_den4", den0, 2'b01);
    cyc();
    chk("upd_den_next", den0, 2'b10);
    chk("upd_seg_d1", seg0, 7'h7E);
    chk("upd_seg_d1_b", seg1, 7'h00);

    show(2'b01, 8'h00, 8'h03, 8'h03, 1'b0, 7'h79, 7'h7E, 7'h00);
    show(2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 7'h7E, 7'h7E, 7'h00);

    // back-to-back strobes
    in_valid = 1'b1; op_code = 2'b00; a = 8'hFF; b = 8'h01; cyc();
    chk("b2b_res0", res0, 8'h00);
    chk("b2b_flag0", flag0, 1'b1);
    op_code = 2'b10; a = 8'h10; b = 8'h20; cyc();
    chk("b2b_res1", res0, 8'hF0);
    chk("b2b_flag1", flag0, 1'b1);
    in_valid = 1'b0; cyc();

    // reset during digit 1
    for (int i = 0; i < 12 && den0 !== 2'b10; i++) cyc();
    chk("reach_dig1", den0, 2'b10);
    rst_n = 1'b0; cyc();
    chk("mrst_res", res0, 8'h00);
    chk("mrst_seg", seg0, 7'h00);
    chk("mrst_den", den0, 2'b00);
    rst_n = 1'b1; cyc();
    cyc();
    chk("mrst_resume_den", den0, 2'b01);
    chk("mrst_resume_seg", seg0, 7'h7E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
